// File: rtl/fpu_mem_master.sv
// Load/store initiator for the SRFPU on the picorv32-native memory bus: one or two word beats per command.
// Optional request watchdog is built when FPU_MEM_WATCHDOG_EN is defined.
`timescale 1ns/1ps
module fpu_mem_master #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_we,
  input  logic        cmd_len,
  input  logic [31:0] cmd_addr,
  input  logic [63:0] cmd_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_rdata,
  output logic        rsp_err,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata,
  output logic        busy
);

  // Handshakes: cmd, rsp and mem each transfer on the edge where valid & ready are both high;
  // valid and its payload are held unchanged until that edge.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_GAP  = 2'd2,
    S_RESP = 2'd3
  } state_t;

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  state_t      state_q, state_d;
  logic        we_q, we_d;
  logic        len_q, len_d;
  logic        beat_q, beat_d;
  logic        err_q, err_d;
  logic [31:0] addr_q, addr_d;
  logic [63:0] wdata_q, wdata_d;
  logic [63:0] rdata_q, rdata_d;
  logic        timeout;

`ifdef FPU_MEM_WATCHDOG_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
  logic [CW-1:0] wd_cnt_q, wd_cnt_d;

  // Counter is zero whenever REQ is entered, since it only runs while stalled in REQ.
  assign timeout  = (state_q == S_REQ) && !mem_ready && (wd_cnt_q == CW'(TIMEOUT_CYCLES - 1));
  assign wd_cnt_d = ((state_q == S_REQ) && !mem_ready) ? wd_cnt_q + 1'b1 : '0;
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    len_d   = len_q;
    beat_d  = beat_q;
    err_d   = err_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          we_d    = cmd_we;
          len_d   = cmd_len;
          addr_d  = cmd_addr;
          wdata_d = cmd_wdata;
          beat_d  = 1'b0;
          rdata_d = '0;
          err_d   = (cmd_addr[1:0] != 2'b00);
          state_d = (cmd_addr[1:0] != 2'b00) ? S_RESP : S_REQ;
        end
      end
      S_REQ: begin
        if (mem_ready) begin
          if (!we_q) begin
            if (beat_q) rdata_d[63:32] = mem_rdata;
            else        rdata_d[31:0]  = mem_rdata;
          end
          if (beat_q == len_q) begin
            err_d   = 1'b0;
            state_d = S_RESP;
          end else begin
            beat_d  = 1'b1;
            addr_d  = addr_q + 32'd4;
            state_d = S_GAP;
          end
        end else if (timeout) begin
          err_d   = 1'b1;
          state_d = S_RESP;
        end
      end
      S_GAP:   state_d = S_REQ;
      S_RESP:  if (rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      we_q     <= 1'b0;
      len_q    <= 1'b0;
      beat_q   <= 1'b0;
      err_q    <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
`ifdef FPU_MEM_WATCHDOG_EN
      wd_cnt_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      len_q    <= len_d;
      beat_q   <= beat_d;
      err_q    <= err_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
`ifdef FPU_MEM_WATCHDOG_EN
      wd_cnt_q <= wd_cnt_d;
`endif
    end
  end

  assign cmd_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign mem_valid = (state_q == S_REQ);
  assign rsp_valid = (state_q == S_RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = beat_q ? wdata_q[63:32] : wdata_q[31:0];
  assign mem_wstrb = {4{we_q}};

endmodule

// File: tb/tb_fpu_mem_master.sv
// Directed bench for fpu_mem_master: a negedge-driven responder with per-beat wait states and a beat log.
`timescale 1ns/1ps
module tb_fpu_mem_master;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_we = 1'b0;
  logic        cmd_len = 1'b0;
  logic [31:0] cmd_addr = '0;
  logic [63:0] cmd_wdata = '0;
  logic        rsp_ready = 1'b0;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        cmd_ready, rsp_valid, rsp_err, mem_valid, busy;
  logic [63:0] rsp_rdata;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;

  int total = 0;
  int bad   = 0;

  fpu_mem_master #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we), .cmd_len(cmd_len),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata), .busy(busy)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "bench timeout");
  end

  // responder: wait states per beat from wait_q, read data from exp_q, completed beats logged
  bit          resp_en = 1'b1;
  int          wait_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] obs_addr[$];
  logic [31:0] obs_wdata[$];
  logic [3:0]  obs_wstrb[$];
  int          vld_cycles = 0;
  int          vld_rises = 0;
  int          addr_changes = 0;
  bit          prev_vld = 1'b0;
  bit          in_beat = 1'b0;
  int          beat_wait = 0;
  logic [31:0] beat_addr = '0;

  always @(negedge clk) begin
    mem_ready = 1'b0;
    mem_rdata = '0;
    if (mem_valid) begin
      vld_cycles++;
      if (!prev_vld) vld_rises++;
      if (!in_beat) begin
        in_beat   = 1'b1;
        beat_addr = mem_addr;
        beat_wait = (wait_q.size() > 0) ? wait_q.pop_front() : 0;
      end else if (mem_addr != beat_addr) begin
        addr_changes++;
      end
      if (resp_en && beat_wait == 0) begin
        mem_ready = 1'b1;
        mem_rdata = (exp_q.size() > 0) ? exp_q.pop_front() : 32'h0;
        obs_addr.push_back(mem_addr);
        obs_wdata.push_back(mem_wdata);
        obs_wstrb.push_back(mem_wstrb);
        in_beat = 1'b0;
      end else if (beat_wait > 0) begin
        beat_wait--;
      end
    end else begin
      in_beat = 1'b0;
    end
    prev_vld = mem_valid;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // driver tasks; each returns at a negedge, first call returns in cycle T+1
  task automatic issue(input logic we, input logic len, input logic [31:0] a, input logic [63:0] wd);
    check("cmd_ready_before_issue", {63'd0, cmd_ready}, 64'd1);
    cmd_valid = 1'b1;
    cmd_we    = we;
    cmd_len   = len;
    cmd_addr  = a;
    cmd_wdata = wd;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int max, output int n);
    n = 0;
    while (!rsp_valid && n < max) begin
      @(negedge clk);
      n++;
    end
    check("rsp_arrived", {63'd0, rsp_valid}, 64'd1);
  endtask

  task automatic finish_rsp();
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("idle_after_rsp", {62'd0, cmd_ready, rsp_valid}, {62'd0, 1'b1, 1'b0});
  endtask

  task automatic clear_log();
    obs_addr.delete();
    obs_wdata.delete();
    obs_wstrb.delete();
  endtask

  int v0, r0, a0, n;

  initial begin
    repeat (3) @(negedge clk);
    check("reset_ctrl", {57'd0, cmd_ready, rsp_valid, rsp_err, mem_valid, busy, mem_wstrb != 4'h0, 1'b0},
          {57'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
    check("reset_rdata", rsp_rdata, 64'd0);
    check("reset_mem", {mem_addr, mem_wdata}, 64'd0);
    check("reset_wstrb", {60'd0, mem_wstrb}, 64'd0);
    reset = 1'b1;
    @(negedge clk);

    // single load, zero wait
    v0 = vld_cycles;
    exp_q.push_back(32'hDEADBEEF);
    issue(1'b0, 1'b0, 32'h0000_2000, 64'd0);
    check("ld1_valid_t1", {63'd0, mem_valid}, 64'd1);
    check("ld1_wstrb", {60'd0, mem_wstrb}, 64'd0);
    check("ld1_addr", {32'd0, mem_addr}, 64'h2000);
    @(negedge clk);
    check("ld1_rsp_t2", {62'd0, rsp_valid, mem_valid}, {62'd0, 1'b1, 1'b0});
    check("ld1_rdata", rsp_rdata, 64'h0000_0000_DEAD_BEEF);
    check("ld1_err", {63'd0, rsp_err}, 64'd0);
    check("ld1_vld_cycles", 64'(vld_cycles - v0), 64'd1);
    finish_rsp();

    // double store, two wait states per beat
    clear_log();
    wait_q.push_back(2);
    wait_q.push_back(2);
    v0 = vld_cycles;
    r0 = vld_rises;
    issue(1'b1, 1'b1, 32'h0000_0100, 64'h1122_3344_5566_7788);
    wait_rsp(50, n);
    check("st2_latency", 64'(n), 64'd7);
    check("st2_vld_cycles", 64'(vld_cycles - v0), 64'd6);
    check("st2_vld_rises", 64'(vld_rises - r0), 64'd2);
    check("st2_beats", 64'(obs_addr.size()), 64'd2);
    if (obs_addr.size() == 2) begin
      check("st2_addr0", {32'd0, obs_addr[0]}, 64'h100);
      check("st2_addr1", {32'd0, obs_addr[1]}, 64'h104);
      check("st2_wdata0", {32'd0, obs_wdata[0]}, 64'h5566_7788);
      check("st2_wdata1", {32'd0, obs_wdata[1]}, 64'h1122_3344);
      check("st2_wstrb", {56'd0, obs_wstrb[0], obs_wstrb[1]}, 64'hFF);
    end
    check("st2_err", {63'd0, rsp_err}, 64'd0);
    check("st2_rdata", rsp_rdata, 64'd0);
    finish_rsp();

    // double load with 10 stall cycles on beat 0
    clear_log();
    wait_q.push_back(10);
    exp_q.push_back(32'hA5A5_A5A5);
    exp_q.push_back(32'h5A5A_5A5A);
    a0 = addr_changes;
    issue(1'b0, 1'b1, 32'h0000_3000, 64'd0);
    wait_rsp(50, n);
    check("ct_latency", 64'(n), 64'd13);
    check("ct_addr_stable", 64'(addr_changes - a0), 64'd0);
    check("ct_rdata", rsp_rdata, 64'h5A5A_5A5A_A5A5_A5A5);
    check("ct_err", {63'd0, rsp_err}, 64'd0);
    if (obs_addr.size() == 2) check("ct_addr1", {32'd0, obs_addr[1]}, 64'h3004);
    else check("ct_beats", 64'(obs_addr.size()), 64'd2);
    finish_rsp();

    // misaligned load: immediate error response, no bus traffic, stale data cleared
    v0 = vld_cycles;
    issue(1'b0, 1'b0, 32'h0000_0102, 64'd0);
    check("mis_rsp_t1", {62'd0, rsp_valid, mem_valid}, {62'd0, 1'b1, 1'b0});
    check("mis_err", {63'd0, rsp_err}, 64'd1);
    check("mis_rdata", rsp_rdata, 64'd0);
    repeat (2) @(negedge clk);
    check("mis_no_bus", 64'(vld_cycles - v0), 64'd0);
    finish_rsp();

    // double load wrapping past the top of the address space
    clear_log();
    exp_q.push_back(32'h0000_1111);
    exp_q.push_back(32'h0000_2222);
    issue(1'b0, 1'b1, 32'hFFFF_FFFC, 64'd0);
    wait_rsp(50, n);
    if (obs_addr.size() == 2) check("wrap_addr1", {32'd0, obs_addr[1]}, 64'h0);
    else check("wrap_beats", 64'(obs_addr.size()), 64'd2);
    check("wrap_rdata", rsp_rdata, 64'h0000_2222_0000_1111);
    check("wrap_err", {63'd0, rsp_err}, 64'd0);
    finish_rsp();

    // response backpressure, then reset during beat 1 of the next command
    exp_q.push_back(32'hCAFE_F00D);
    issue(1'b0, 1'b0, 32'h0000_0040, 64'd0);
    wait_rsp(50, n);
    check("bp_latency", 64'(n), 64'd1);
    for (int i = 0; i < 5; i++) begin
      check("bp_hold_valid", {63'd0, rsp_valid}, 64'd1);
      check("bp_hold_rdata", rsp_rdata, 64'h0000_0000_CAFE_F00D);
      @(negedge clk);
    end
    finish_rsp();
    exp_q.push_back(32'h0000_0001);
    exp_q.push_back(32'h0000_0002);
    issue(1'b0, 1'b1, 32'h0000_0080, 64'd0);
    @(negedge clk);
    check("rst_gap", {63'd0, mem_valid}, 64'd0);
    @(negedge clk);
    check("rst_beat1", {31'd0, mem_valid, mem_addr}, {31'd0, 1'b1, 32'h84});
    reset = 1'b0;
    @(negedge clk);
    check("rst_state", {60'd0, mem_valid, rsp_valid, cmd_ready, busy}, {60'd0, 4'b0010});
    reset = 1'b1;
    exp_q.delete();
    wait_q.delete();
    @(negedge clk);
    check("rst_no_partial_rsp", {63'd0, rsp_valid}, 64'd0);

    // responder never answers
    resp_en = 1'b0;
    v0 = vld_cycles;
    issue(1'b0, 1'b0, 32'h0000_0200, 64'd0);
`ifdef FPU_MEM_WATCHDOG_EN
    wait_rsp(50, n);
    check("wd_latency", 64'(n), 64'd8);
    check("wd_vld_cycles", 64'(vld_cycles - v0), 64'd8);
    check("wd_err", {63'd0, rsp_err}, 64'd1);
    check("wd_rdata", rsp_rdata, 64'd0);
    resp_en = 1'b1;
    finish_rsp();
`else
    repeat (20) @(negedge clk);
    check("nowd_still_req", {62'd0, mem_valid, rsp_valid}, {62'd0, 1'b1, 1'b0});
    exp_q.push_back(32'h0000_0077);
    resp_en = 1'b1;
    wait_rsp(10, n);
    check("nowd_rdata", rsp_rdata, 64'h77);
    check("nowd_err", {63'd0, rsp_err}, 64'd0);
    finish_rsp();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
